// File: rtl/addsub_result_stage.sv
// Registered result stage for the adder/subtractor: derives status flags,
// buffers up to two results in a valid/ready FIFO and counts signed overflows.
module addsub_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  input  logic             add_n,
  input  logic             x_msb,
  input  logic             y_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int EW = WIDTH + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [EW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic          carry_in;
  logic          borrow_in;
  logic          zero_in;
  logic          neg_in;
  logic          ovf_in;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] entry_out;
  logic          out_sel;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags are derived from the incoming beat and stored alongside the result.
  assign carry_in  = cout & ~add_n;
  assign borrow_in = ~cout & add_n;
  assign zero_in   = (result == '0);
  assign neg_in    = result[WIDTH-1];
  assign ovf_in    = add_n ? ((x_msb != y_msb) & (neg_in != x_msb))
                           : ((x_msb == y_msb) & (neg_in != x_msb));
  assign entry_in  = {result, carry_in, borrow_in, zero_in, neg_in, ovf_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When empty, the slot behind the read pointer still holds the last popped
  // entry (a push into an empty FIFO writes the other slot), so outputs hold.
  assign out_sel   = out_valid ? rd_ptr : ~rd_ptr;
  assign entry_out = mem[out_sel];

  assign out_result = entry_out[EW-1:5];
  assign out_carry  = entry_out[4];
  assign out_borrow = entry_out[3];
  assign out_zero   = entry_out[2];
  assign out_neg    = entry_out[1];
  assign out_ovf    = entry_out[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (clr_cnt) begin
      ovf_count <= '0;
    end else if (push && ovf_in && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule
